// File: rtl/five_in_row_checker.sv
// Five-in-a-row detector for a 16x16 two-player board: after a stone is placed it
// walks outward from the move along each of the four line directions, one cell per cycle.
module five_in_row_checker (
   input  logic         CLOCK_50,
   input  logic         Reset,
   input  logic [511:0] board,
   input  logic         start,
   input  logic [3:0]   move_x,
   input  logic [3:0]   move_y,
   input  logic [1:0]   player,
   output logic         busy,
   output logic         done,
   output logic         win,
   output logic [1:0]   win_dir
);

   typedef enum logic [1:0] {IDLE, SCAN_POS, SCAN_NEG, DONE} state_t;

   // Step per direction: 0 = (+1,0), 1 = (0,+1), 2 = (+1,+1), 3 = (+1,-1).
   function automatic logic signed [5:0] delta_x(input logic [1:0] d);
      case (d)
         2'd0:    delta_x = 6'sd1;
         2'd1:    delta_x = 6'sd0;
         2'd2:    delta_x = 6'sd1;
         2'd3:    delta_x = 6'sd1;
         default: delta_x = 6'sd0;
      endcase
   endfunction

   function automatic logic signed [5:0] delta_y(input logic [1:0] d);
      case (d)
         2'd0:    delta_y = 6'sd0;
         2'd1:    delta_y = 6'sd1;
         2'd2:    delta_y = 6'sd1;
         2'd3:    delta_y = -6'sd1;
         default: delta_y = 6'sd0;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [511:0]        board_q, board_d;
   logic [3:0]          ox_q, ox_d, oy_q, oy_d;
   logic [1:0]          player_q, player_d;
   logic [1:0]          dir_q, dir_d;
   logic [2:0]          count_q, count_d;
   logic signed [5:0]   cx_q, cx_d, cy_q, cy_d;
   logic                win_q, win_d;
   logic [1:0]          win_dir_q, win_dir_d;
   logic                busy_q, busy_d, done_q, done_d;

   logic [1:0]          cell_s, dir_nx_s;
   logic                in_bounds_s, hit_s;
   logic signed [5:0]   ox_s, oy_s;

   // Cursor cell lookup; out-of-range coordinates have a nonzero upper bit pair.
   always_comb begin
      ox_s        = $signed({2'b00, ox_q});
      oy_s        = $signed({2'b00, oy_q});
      dir_nx_s    = dir_q + 2'd1;
      cell_s      = board_q[{cy_q[3:0], cx_q[3:0], 1'b0} +: 2];
      in_bounds_s = (cx_q[5:4] == 2'b00) && (cy_q[5:4] == 2'b00);
      hit_s       = in_bounds_s && (cell_s == player_q) && (count_q < 3'd5);
   end

   // Next-state and datapath updates for the scan sequencer.
   always_comb begin
      state_d   = state_q;
      board_d   = board_q;
      ox_d      = ox_q;
      oy_d      = oy_q;
      player_d  = player_q;
      dir_d     = dir_q;
      count_d   = count_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      win_d     = win_q;
      win_dir_d = win_dir_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               board_d   = board;
               ox_d      = move_x;
               oy_d      = move_y;
               player_d  = player;
               win_d     = 1'b0;
               win_dir_d = 2'd0;
               dir_d     = 2'd0;
               count_d   = 3'd1;
               cx_d      = $signed({2'b00, move_x}) + delta_x(2'd0);
               cy_d      = $signed({2'b00, move_y}) + delta_y(2'd0);
               if ((player == 2'b00) || (player == 2'b11)) begin
                  state_d = DONE;
               end else begin
                  state_d = SCAN_POS;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SCAN_POS: begin
            if (hit_s) begin
               count_d = count_q + 3'd1;
               cx_d    = cx_q + delta_x(dir_q);
               cy_d    = cy_q + delta_y(dir_q);
            end else begin
               cx_d    = ox_s - delta_x(dir_q);
               cy_d    = oy_s - delta_y(dir_q);
               state_d = SCAN_NEG;
            end
         end
         SCAN_NEG: begin
            if (hit_s) begin
               count_d = count_q + 3'd1;
               cx_d    = cx_q - delta_x(dir_q);
               cy_d    = cy_q - delta_y(dir_q);
            end else if (count_q >= 3'd5) begin
               win_d     = 1'b1;
               win_dir_d = dir_q;
               state_d   = DONE;
            end else if (dir_q != 2'd3) begin
               dir_d   = dir_nx_s;
               count_d = 3'd1;
               cx_d    = ox_s + delta_x(dir_nx_s);
               cy_d    = oy_s + delta_y(dir_nx_s);
               state_d = SCAN_POS;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State, snapshot and registered outputs.
   always_ff @(posedge CLOCK_50 or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         board_q   <= 512'd0;
         ox_q      <= 4'd0;
         oy_q      <= 4'd0;
         player_q  <= 2'd0;
         dir_q     <= 2'd0;
         count_q   <= 3'd0;
         cx_q      <= 6'sd0;
         cy_q      <= 6'sd0;
         win_q     <= 1'b0;
         win_dir_q <= 2'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         board_q   <= board_d;
         ox_q      <= ox_d;
         oy_q      <= oy_d;
         player_q  <= player_d;
         dir_q     <= dir_d;
         count_q   <= count_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         win_q     <= win_d;
         win_dir_q <= win_dir_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign win     = win_q;
   assign win_dir = win_dir_q;

endmodule
